// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: mem_op codes,
// FSM states and byte-lane constants.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to the load opcode.
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        // addr[0] is ignored for halfwords so misaligned accesses fall back to the aligned lane.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (mem_op_e'(op_i))
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'd0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller: IDLE -> REQ -> DONE handshake with
// ack timeout. Define MEM_ALIGN_EXC_EN to trap misaligned accesses.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic [2:0]  exmem_mem_op,
    input  logic [31:0] exmem_addr,
    input  logic [31:0] exmem_rt_data,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_data,
    output logic [3:0]  reg_byte_w_en,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        addr_exc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e state_q, state_d;

    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             load_q, load_d;
    mem_op_e          op_q, op_d;
    logic [1:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             err_q, err_d;
    logic             exc_q, exc_d;

    mem_op_e     in_op;
    logic        req_valid;
    logic        misaligned_in;
    logic        timeout_hit;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] aligned_data;

    assign in_op       = mem_op_e'(exmem_mem_op);
    assign req_valid   = exmem_mem_r | exmem_mem_w;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_ALIGN_EXC_EN
    assign misaligned_in = is_misaligned(in_op, exmem_addr[1:0]);
    assign addr_exc      = exc_q;
`else
    assign misaligned_in = 1'b0;
    assign addr_exc      = 1'b0;
`endif

    always_comb begin
        store_be    = BE_WORD;
        store_wdata = exmem_rt_data;
        case (in_op)
            OP_SB: begin
                store_be    = BE_BYTE0 << exmem_addr[1:0];
                store_wdata = {4{exmem_rt_data[7:0]}};
            end
            OP_SH: begin
                store_be    = exmem_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                store_wdata = {2{exmem_rt_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .op_i      (op_q),
        .addr_lo_i (lo_q),
        .rdata_i   (dbus_rdata),
        .data_o    (aligned_data)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = misaligned_in ? ST_DONE : ST_REQ;
            ST_REQ:  if (dbus_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_stall     = (state_q == ST_IDLE && req_valid) || state_q == ST_REQ;
        reg_byte_w_en = (state_q == ST_DONE && load_q && !err_q && !exc_q) ? BE_WORD : BE_NONE;
    end

    // Datapath: capture the request in IDLE, resolve it when REQ ends.
    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        load_d     = load_q;
        op_d       = op_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        mem_data_d = mem_data_q;
        err_d      = 1'b0;
        exc_d      = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                load_d = !exmem_mem_w;
                op_d   = in_op;
                lo_d   = exmem_addr[1:0];
                cnt_d  = '0;
                if (misaligned_in) begin
                    exc_d = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    we_d    = exmem_mem_w;
                    addr_d  = {exmem_addr[31:2], 2'b00};
                    be_d    = exmem_mem_w ? store_be : BE_WORD;
                    wdata_d = store_wdata;
                end
            end
            ST_REQ: begin
                if (dbus_ack) begin
                    req_d = 1'b0;
                    if (load_q) mem_data_d = aligned_data;
                end else if (timeout_hit) begin
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    mem_data_d = '0;
                    cnt_d      = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= BE_NONE;
            load_q     <= 1'b0;
            op_q       <= OP_LB;
            lo_q       <= 2'b00;
            cnt_q      <= '0;
            mem_data_q <= '0;
            err_q      <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            load_q     <= load_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
            err_q      <= err_d;
            exc_q      <= exc_d;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_wdata = wdata_q;
    assign dbus_be    = be_q;
    assign mem_data   = mem_data_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model,
// per-cycle compare process, directed pins plus randomized accesses.
module tb_mem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        exmem_mem_r, exmem_mem_w;
    logic [2:0]  exmem_mem_op;
    logic [31:0] exmem_addr, exmem_rt_data;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] mem_data;
    logic [3:0]  reg_byte_w_en;
    logic        mem_stall, bus_err, addr_exc;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .exmem_mem_r   (exmem_mem_r),
        .exmem_mem_w   (exmem_mem_w),
        .exmem_mem_op  (exmem_mem_op),
        .exmem_addr    (exmem_addr),
        .exmem_rt_data (exmem_rt_data),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_wdata    (dbus_wdata),
        .dbus_be       (dbus_be),
        .dbus_ack      (dbus_ack),
        .dbus_rdata    (dbus_rdata),
        .mem_data      (mem_data),
        .reg_byte_w_en (reg_byte_w_en),
        .mem_stall     (mem_stall),
        .bus_err       (bus_err),
        .addr_exc      (addr_exc)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected values for the current cycle, written by the driver.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_err, exp_exc, exp_fields;
    logic [31:0] exp_addr, exp_wdata, exp_mem;
    logic [3:0]  exp_be, exp_rbw;

    int          stall_cnt;
    logic        req_seen;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall", mem_stall, exp_stall);
            check("dbus_req", dbus_req, exp_req);
            check("bus_err", bus_err, exp_err);
            check("addr_exc", addr_exc, exp_exc);
            check("reg_byte_w_en", reg_byte_w_en, exp_rbw);
            check("mem_data", mem_data, exp_mem);
            if (exp_fields) begin
                check("dbus_addr", dbus_addr, exp_addr);
                check("dbus_we", dbus_we, exp_we);
                if (exp_we) begin
                    check("dbus_be", dbus_be, exp_be);
                    check("dbus_wdata", dbus_wdata, exp_wdata);
                end
            end
            if (mem_stall) stall_cnt++;
            if (dbus_req) begin
                req_seen  = 1'b1;
                cap_addr  = dbus_addr;
                cap_wdata = dbus_wdata;
                cap_be    = dbus_be;
                cap_we    = dbus_we;
            end
        end
    end

    // Reference model: plain arithmetic on the architectural rules.
    function automatic logic [31:0] model_load(logic [2:0] op, logic [31:0] a, logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
        h = (rd >> (16 * a[1])) & 32'h0000_FFFF;
        case (op)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return b;
            3'd2:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd3:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] op, logic [31:0] a);
        case (op)
            3'd5:    return 4'b0001 << a[1:0];
            3'd6:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] op, logic [31:0] rt);
        case (op)
            3'd5:    return {4{rt[7:0]}};
            3'd6:    return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    function automatic logic model_misaligned(logic [2:0] op, logic [31:0] a);
`ifdef MEM_ALIGN_EXC_EN
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return a[0];
        if (op == 3'd4 || op == 3'd7) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stall  = 1'b0;
        exp_req    = 1'b0;
        exp_rbw    = 4'b0000;
        exp_err    = 1'b0;
        exp_exc    = 1'b0;
        exp_fields = 1'b0;
    endtask

    // One access: IDLE cycle, REQ cycles until ack (d in 1..T) or timeout, DONE.
    // Returns during the DONE cycle.
    task automatic do_access(input logic [2:0] op, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] rt,
                             input logic [31:0] rd, input int d);
        int  n;
        logic to;
        step();
        exmem_mem_r   = r;
        exmem_mem_w   = w;
        exmem_mem_op  = op;
        exmem_addr    = a;
        exmem_rt_data = rt;
        dbus_ack      = 1'($urandom);
        dbus_rdata    = $urandom;
        stall_cnt     = 0;
        req_seen      = 1'b0;
        idle_exp();
        exp_stall = 1'b1;
        if (model_misaligned(op, a)) begin
            step();
            dbus_ack = 1'($urandom);
            idle_exp();
            exp_exc = 1'b1;
            return;
        end
        to = !(d >= 1 && d <= T);
        n  = to ? T : d;
        for (int k = 1; k <= n; k++) begin
            step();
            dbus_ack   = (k == d);
            dbus_rdata = (k == d) ? rd : $urandom;
            exp_stall  = 1'b1;
            exp_req    = 1'b1;
            exp_fields = 1'b1;
            exp_we     = w;
            exp_addr   = {a[31:2], 2'b00};
            exp_be     = model_be(op, a);
            exp_wdata  = model_wdata(op, rt);
        end
        step();
        dbus_ack   = 1'($urandom);
        dbus_rdata = $urandom;
        idle_exp();
        exp_err = to;
        if (to)      exp_mem = 32'd0;
        else if (!w) exp_mem = model_load(op, a, rd);
        exp_rbw = (!w && !to) ? 4'b1111 : 4'b0000;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            exmem_mem_r = 1'b0;
            exmem_mem_w = 1'b0;
            dbus_ack    = 1'($urandom);
            dbus_rdata  = $urandom;
            idle_exp();
        end
    endtask

    initial begin
        reset         = 1'b1;
        exmem_mem_r   = 1'b0;
        exmem_mem_w   = 1'b0;
        exmem_mem_op  = 3'd0;
        exmem_addr    = '0;
        exmem_rt_data = '0;
        dbus_ack      = 1'b0;
        dbus_rdata    = '0;
        stall_cnt     = 0;
        req_seen      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst dbus_req", dbus_req, 1'b0);
        check("rst dbus_we", dbus_we, 1'b0);
        check("rst dbus_addr", dbus_addr, 32'd0);
        check("rst dbus_wdata", dbus_wdata, 32'd0);
        check("rst dbus_be", dbus_be, 4'd0);
        check("rst mem_data", mem_data, 32'd0);
        check("rst bus_err", bus_err, 1'b0);
        check("rst addr_exc", addr_exc, 1'b0);
        check("rst mem_stall", mem_stall, 1'b0);

        step();
        reset   = 1'b0;
        idle_exp();
        exp_mem = 32'd0;
        chk_en  = 1'b1;
        gap(2);

        // LB at 0x103, zero-wait ack.
        do_access(3'd0, 1'b1, 1'b0, 32'h0000_0103, $urandom, 32'h80FF_1234, 1);
        @(negedge clk);
        check("lb data", mem_data, 32'hFFFF_FF80);
        check("lb rbw", reg_byte_w_en, 4'b1111);
        check("lb stall cycles", stall_cnt, 2);

        // SH at 0x202.
        do_access(3'd6, 1'b0, 1'b1, 32'h0000_0202, 32'h0000_BEEF, $urandom, 2);
        @(negedge clk);
        check("sh addr", cap_addr, 32'h0000_0200);
        check("sh be", cap_be, 4'b1100);
        check("sh wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh we", cap_we, 1'b1);
        check("sh rbw", reg_byte_w_en, 4'b0000);

        // LW timeout with ack withheld, then ack on the last allowed cycle.
        do_access(3'd4, 1'b1, 1'b0, 32'h0000_0040, $urandom, $urandom, 0);
        @(negedge clk);
        check("to bus_err", bus_err, 1'b1);
        check("to mem_data", mem_data, 32'd0);
        check("to rbw", reg_byte_w_en, 4'b0000);
        check("to stall cycles", stall_cnt, 5);
        do_access(3'd4, 1'b1, 1'b0, 32'h0000_0040, $urandom, 32'h1234_5678, T);
        @(negedge clk);
        check("ack@T bus_err", bus_err, 1'b0);
        check("ack@T mem_data", mem_data, 32'h1234_5678);
        check("ack@T rbw", reg_byte_w_en, 4'b1111);

        // Misaligned LW at 0x101.
        do_access(3'd4, 1'b1, 1'b0, 32'h0000_0101, $urandom, 32'hCAFE_F00D, 1);
        @(negedge clk);
`ifdef MEM_ALIGN_EXC_EN
        check("misal addr_exc", addr_exc, 1'b1);
        check("misal req_seen", req_seen, 1'b0);
        check("misal rbw", reg_byte_w_en, 4'b0000);
`else
        check("misal addr", cap_addr, 32'h0000_0100);
        check("misal data", mem_data, 32'hCAFE_F00D);
        check("misal addr_exc", addr_exc, 1'b0);
`endif

        // Back-to-back LBU at 0x0 and 0x1.
        do_access(3'd1, 1'b1, 1'b0, 32'h0000_0000, $urandom, 32'h0000_A5C3, 1);
        @(negedge clk);
        check("lbu0 data", mem_data, 32'h0000_00C3);
        check("lbu0 stall cycles", stall_cnt, 2);
        do_access(3'd1, 1'b1, 1'b0, 32'h0000_0001, $urandom, 32'h0000_A5C3, 1);
        @(negedge clk);
        check("lbu1 data", mem_data, 32'h0000_00A5);
        check("lbu1 stall cycles", stall_cnt, 2);

        // Reset in the 2nd wait cycle of a load, coinciding with ack; then a late ack.
        step();
        exmem_mem_r  = 1'b1;
        exmem_mem_w  = 1'b0;
        exmem_mem_op = 3'd4;
        exmem_addr   = 32'h0000_0300;
        dbus_ack     = 1'b0;
        idle_exp();
        exp_stall = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            dbus_ack   = (k == 2);
            dbus_rdata = 32'hDEAD_BEEF;
            reset      = (k == 2);
            exp_stall  = 1'b1;
            exp_req    = 1'b1;
            exp_fields = 1'b1;
            exp_we     = 1'b0;
            exp_addr   = 32'h0000_0300;
        end
        step();
        reset       = 1'b0;
        exmem_mem_r = 1'b0;
        dbus_ack    = 1'b1;
        idle_exp();
        exp_mem = 32'd0;
        @(negedge clk);
        check("rst-mid dbus_req", dbus_req, 1'b0);
        check("rst-mid dbus_addr", dbus_addr, 32'd0);
        check("rst-mid mem_data", mem_data, 32'd0);
        step();
        dbus_ack = 1'b0;
        @(negedge clk);
        check("late ack stall", mem_stall, 1'b0);
        check("late ack rbw", reg_byte_w_en, 4'b0000);
        check("late ack req", dbus_req, 1'b0);

        // Randomized accesses.
        repeat (60) begin
            logic [2:0] op;
            logic       r, w;
            op = 3'($urandom_range(0, 7));
            if (op >= 3'd5) begin
                w = 1'b1;
                r = 1'($urandom);
            end else begin
                r = 1'b1;
                w = 1'b0;
            end
            do_access(op, r, w, $urandom, $urandom, $urandom, $urandom_range(0, T + 2));
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
        gap(1);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ-state cycles without dbus_ack before the access is aborted.
REQ-002 Port clk, input, 1: clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: reset, synchronous, active-high.
REQ-004 Port exmem_mem_r / exmem_mem_w, input, 1 each: load / store request from EX/MEM; both high is treated as store.
REQ-005 Port exmem_mem_op, input, 3: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
REQ-006 Port exmem_addr / exmem_rt_data, input, 32 each: byte address; store source data.
REQ-007 Ports dbus_req, dbus_we (output, 1), dbus_addr, dbus_wdata (output, 32), dbus_be (output, 4): registered data-bus request; dbus_addr always has bits [1:0] = 0.
REQ-008 Ports dbus_ack (input, 1), dbus_rdata (input, 32): bus completion and read data, valid together.
REQ-009 Ports mem_data (output, 32), reg_byte_w_en (output, 4), mem_stall (output, 1), bus_err (output, 1), addr_exc (output, 1): results for the MEM/WB register.

Function
REQ-010 FSM states: IDLE, REQ, DONE.
REQ-011 IDLE with exmem_mem_r or exmem_mem_w high SHALL go to REQ and register dbus_req=1, dbus_we, dbus_addr={addr[31:2],2'b00}, dbus_be, dbus_wdata.
REQ-012 Store lanes: SB be=1<<addr[1:0], wdata=rt[7:0] replicated x4; SH be=addr[1]?4'b1100:4'b0011, wdata=rt[15:0] replicated x2; SW be=4'b1111, wdata=rt.
REQ-013 REQ holds all dbus outputs stable until dbus_ack is sampled high, then goes to DONE and drops dbus_req on that edge.
REQ-014 On ack of a load, dbus_rdata SHALL be captured; mem_data = selected lane, sign-extended (LB, LH) or zero-extended (LBU, LHU); LW passes the full word.
REQ-015 reg_byte_w_en SHALL be 4'b1111 in DONE for a completed load and 4'b0000 otherwise.
REQ-016 mem_stall SHALL equal (state==IDLE && (mem_r||mem_w)) || state==REQ; it is combinational and low in DONE.
REQ-017 DONE lasts exactly one cycle and then goes to IDLE; back-to-back accesses therefore take 3 cycles minimum each, with zero-wait ack.
REQ-018 A timeout counter SHALL clear on entry to REQ and increment for each REQ cycle without ack.
REQ-019 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with dbus_req=0, bus_err=1 for that DONE cycle, mem_data=0 and reg_byte_w_en=0.
REQ-020 An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal completion, no bus_err.
REQ-021 A dbus_ack arriving in IDLE or DONE SHALL be ignored.
REQ-022 mem_data SHALL hold its value outside DONE.

Reset
REQ-023 When reset is high at a clock edge: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_be=0, mem_data=0, timeout counter=0, bus_err=0, addr_exc=0.
REQ-024 Reset asserted mid-access SHALL abandon the access and take priority over ack; dbus_req is low on the cycle after the reset edge.

Configuration
REQ-025 Macro MEM_ALIGN_EXC_EN defined: a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) in IDLE SHALL skip REQ and go directly to DONE with addr_exc=1 for one cycle, no bus request, and reg_byte_w_en=0.
REQ-026 Macro MEM_ALIGN_EXC_EN undefined: offending low address bits SHALL be ignored (forced to 0 for lane selection), the access proceeds normally, and addr_exc is tied to 0.

Structure
REQ-027 Package mem_pkg SHALL hold the mem_op encodings, the FSM state enum and the lane-select constants.
REQ-028 A combinational sub-module load_align SHALL perform lane select and extension for REQ-014.

Verification
REQ-029 LB at addr 0x103 with rdata 0x80FF_1234 and ack in the first REQ cycle -> mem_data=0xFFFF_FF80, reg_byte_w_en=4'b1111, mem_stall high for exactly 2 cycles.
REQ-030 SH at addr 0x202 with rt=0x0000_BEEF -> dbus_addr=0x200, be=4'b1100, wdata=0xBEEF_BEEF, dbus_we=1.
REQ-031 LW with ack withheld and TIMEOUT_CYCLES=4 -> after 4 REQ cycles bus_err=1 for one cycle and mem_data=0; a second case with ack on the 4th cycle -> normal completion, no bus_err.
REQ-032 Reset asserted in the 2nd wait cycle of a load -> next cycle dbus_req=0 and state IDLE; a late ack is ignored.
REQ-033 With MEM_ALIGN_EXC_EN, LW at 0x101 -> addr_exc=1, dbus_req never asserted; without the macro -> dbus_addr=0x100 and a normal load.
REQ-034 Two back-to-back LBU at 0x0 and 0x1 with rdata 0x0000_A5C3 -> mem_data 0xC3 then 0xA5, each access taking 3 cycles.
